// File: rtl/byte_normalizer_pkg.sv
// Shared types and helpers for the byte-stepped left normalizer.
package byte_normalizer_pkg;

  // Bits scanned per SHIFT cycle.
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to hold a shift amount of 0..w inclusive.
  function automatic int shamt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/byte_normalizer_lzc8.sv
// 8-bit leading-zero counter: returns 0..8 (8 when the byte is all zeros).
module byte_normalizer_lzc8 (
  input  logic [7:0] val_i,
  output logic [3:0] cnt_o
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt_o = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (val_i[i]) cnt_o = 4'(7 - i);
    end
  end

endmodule

// File: rtl/byte_normalizer.sv
// Sequential left normalizer: skips one all-zero byte per cycle, then
// finishes with a sub-byte shift taken from the top-byte leading-zero count.
module byte_normalizer
  import byte_normalizer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = shamt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_zero
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int BL_W   = $clog2(NBYTES + 1);

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] count_q;
  logic [BL_W-1:0]    bytes_left_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SHAMT_W-1:0] out_shamt_q;
  logic               out_zero_q;

  logic [3:0]         lz;
  logic [WIDTH-1:0]   norm_d;
  logic [SHAMT_W-1:0] shamt_d;

  byte_normalizer_lzc8 u_lzc8 (
    .val_i (work_q[WIDTH-1 -: BYTE_W]),
    .cnt_o (lz)
  );

  // Final sub-byte shift and total count, only used when the top byte is non-zero.
  assign norm_d  = work_q << lz[2:0];
  assign shamt_d = count_q + SHAMT_W'(lz);

  // Control FSM with registered result outputs; flush overrides any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      count_q      <= '0;
      bytes_left_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_shamt_q  <= '0;
      out_zero_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q       <= in_data;
            count_q      <= '0;
            bytes_left_q <= BL_W'(NBYTES);
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (lz == 4'd8) begin
            if (bytes_left_q > BL_W'(1)) begin
              work_q       <= work_q << BYTE_W;
              count_q      <= count_q + SHAMT_W'(BYTE_W);
              bytes_left_q <= bytes_left_q - BL_W'(1);
            end else begin
              // Last byte scanned and still zero: the whole operand was zero.
              out_data_q  <= '0;
              out_shamt_q <= SHAMT_W'(WIDTH);
              out_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            out_data_q  <= norm_d;
            out_shamt_q <= shamt_d;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shamt = out_shamt_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_byte_normalizer.sv
// Directed bench for byte_normalizer (WIDTH=32).
module tb_byte_normalizer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_shamt;
  logic        out_zero;

  int checks_total;
  int checks_passed;

  byte_normalizer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one operand, accept it, and wait (bounded) for out_valid.
  // Returns the latency in cycles counted from the cycle in which it was accepted.
  task automatic start_op(input logic [31:0] data, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] data, input logic [31:0] exp_data,
                        input int exp_shamt, input logic exp_zero, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    start_op(data, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, out_data, exp_data);
    check({tag, " shamt"}, 32'(out_shamt), 32'(exp_shamt));
    check({tag, " zero"}, 32'(out_zero), 32'(exp_zero));
    @(negedge clk);
    check({tag, " valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    checks_total  = 0;
    checks_passed = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst data", out_data, 32'd0);
    check("rst shamt", 32'(out_shamt), 32'd0);
    check("rst zero", 32'(out_zero), 32'd0);
    check("rst ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("msb set", 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 2);
    run_op("k1", 32'h0001_2345, 32'h91A2_8000, 15, 1'b0, 3);
    run_op("one", 32'h0000_0001, 32'h8000_0000, 31, 1'b0, 5);
    run_op("zero", 32'h0000_0000, 32'h0000_0000, 32, 1'b1, 5);

    // Backpressure: result holds while the consumer stalls.
    out_ready = 1'b0;
    start_op(32'h0F00_0000, lat);
    check("bp latency", 32'(lat), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp data", out_data, 32'hF000_0000);
      check("bp shamt", 32'(out_shamt), 32'd4);
      check("bp ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp valid drop", 32'(out_valid), 32'd0);
    check("bp ready back", 32'(in_ready), 32'd1);

    // Flush while shifting: no result is ever presented.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(negedge clk);
    in_valid = 1'b0;
    check("fl in shift", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("fl no valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    run_op("after fl", 32'h4000_0000, 32'h8000_0000, 1, 1'b0, 2);

    // Flush in IDLE beats in_valid: operand is not accepted.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0080;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl idle no accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("fl idle no valid", 32'(out_valid), 32'd0);

    // Flush in DONE drops the result even with out_ready high.
    out_ready = 1'b0;
    start_op(32'h0000_0080, lat);
    check("fd valid", 32'(out_valid), 32'd1);
    check("fd shamt", 32'(out_shamt), 32'd24);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fd dropped", 32'(out_valid), 32'd0);
    check("fd idle", 32'(in_ready), 32'd1);

    // Asynchronous reset while in DONE.
    out_ready = 1'b0;
    start_op(32'h0001_2345, lat);
    check("ar valid before", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar valid", 32'(out_valid), 32'd0);
    check("ar data", out_data, 32'd0);
    check("ar shamt", 32'(out_shamt), 32'd0);
    check("ar zero", 32'(out_zero), 32'd0);
    check("ar ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_op("after rst", 32'h0000_0300, 32'hC000_0000, 22, 1'b0, 4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/byte_normalizer.md
Name: byte_normalizer

Overview:
Sequential left-normalizer for floating-point and bit-manipulation datapaths. It accepts a WIDTH-bit operand and shifts it left until the MSB is 1. It returns the normalized value and the total shift amount. This is the reconstruction counterpart of the 8-bit leading-zero counter: it consumes one byte-level count per cycle and scans at most 8 bit positions per cycle, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 16.
SHAMT_W, $clog2(WIDTH+1), width of the shift-amount output (6 for WIDTH=32).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous abort; returns the block to IDLE.
in_valid  in  1  operand valid.
in_ready  out  1  block can accept an operand.
in_data  in  WIDTH  operand.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  WIDTH  normalized operand (MSB=1 unless zero).
out_shamt  out  SHAMT_W  total left-shift applied.
out_zero  out  1  operand was all zeros.

Behaviour:
- Reset and clocking: one clock. Reset is asynchronous and active-low (rst_n). On reset, state=IDLE and out_valid, out_data, out_shamt and out_zero are all 0.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1, latch in_data into the work register, clear the count and bytes_left=WIDTH/8, then go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Compute c = leading-zero count of work[WIDTH-1 -: 8] (0..8).
  - If c==8 and bytes_left>1: work <<= 8, count += 8, bytes_left -= 1, stay in SHIFT.
  - If c==8 and bytes_left==1: the operand is zero. Set out_data=0, out_shamt=WIDTH, out_zero=1, go to DONE.
  - If c<8: out_data = work << c, out_shamt = count + c, out_zero=0, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data, out_shamt and out_zero hold stable while out_ready=0.
  - When out_ready=1, transfer the result and go to IDLE. out_valid is 0 in the next cycle.
- Latency: let k = number of leading all-zero bytes (k < WIDTH/8).
  - out_valid asserts k+2 cycles after the accept edge.
  - For an all-zero operand it asserts WIDTH/8+1 cycles after the accept edge.
- Throughput: one operation in flight. There is no input/output overlap; in_ready is 1 only in IDLE.
- Arithmetic: the count never exceeds WIDTH and fits in SHAMT_W bits. Shifts are logical and zero-filled.
- Flush:
  - flush=1 in any state forces IDLE on the next edge and clears out_valid.
  - flush has priority over in_valid and out_ready in the same cycle. The operand in IDLE is not accepted, and the result in DONE is dropped.
- Reset mid-operation: asynchronous clear to reset values. No partial result is ever presented.
- Interface rules:
  - in_valid and in_data are sampled only in IDLE.
  - Changes to in_data in other states have no effect.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the function shamt_width(WIDTH);
  - the constant BYTE_W=8.
- One sub-module is natural: the existing 8-bit leading-zero counter (8-bit value in, 4-bit count 0..8 out). It is instantiated once on the top byte of the work register.
- Everything else (the shifter, count and bytes_left registers) lives in byte_normalizer.

Test Plan:
- in_data=0x80000000, out_ready=1 -> out_data=0x80000000, out_shamt=0, out_zero=0, out_valid 2 cycles after accept.
- in_data=0x00012345 -> out_data=0x91A28000, out_shamt=15, out_zero=0, out_valid 3 cycles after accept.
- in_data=0x00000001 -> out_data=0x80000000, out_shamt=31, out_valid 5 cycles after accept.
- in_data=0x00000000 -> out_data=0, out_shamt=32, out_zero=1, out_valid 5 cycles after accept.
- Backpressure:
  - Stimulus: in_data=0x0F000000 with out_ready=0 for 4 cycles.
  - Response: out_valid stays 1, out_data=0xF0000000 and out_shamt=4 are stable, and in_ready=0 throughout.
  - Then raise out_ready: one transfer, IDLE next cycle, and in_ready=1.
- Abort:
  - Stimulus: flush=1 while in SHIFT with in_data=0x00000001.
  - Response: no out_valid, IDLE next cycle; a following operand 0x40000000 yields shamt=1.
  - Stimulus: rst_n=0 asynchronously while in DONE.
  - Response: out_valid=0 immediately and all outputs are 0.
